// File: rtl/config_pkg.sv
// Build-time defaults for the memory port arbiter.
package config_pkg;

  localparam int unsigned CFG_MEMARB_BURST   = 4;
  localparam int unsigned CFG_MEMARB_TIMEOUT = 255;

endpackage : config_pkg

// File: rtl/data_bus_pkg.sv
// Shared types for the single-port memory arbiter: FSM states and the latched request.
package data_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        wen;
    logic        is_instr;
  } mem_req_t;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Fetches are always full-word reads; nothing else from the fetch side matters.
  function automatic mem_req_t make_fetch_req(input logic [31:0] addr);
    mem_req_t req;
    req.addr     = addr;
    req.wdata    = 32'h0000_0000;
    req.size     = SIZE_WORD;
    req.wen      = 1'b0;
    req.is_instr = 1'b1;
    return req;
  endfunction

  function automatic mem_req_t make_data_req(input logic [31:0] addr,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic        wen);
    mem_req_t req;
    req.addr     = addr;
    req.wdata    = wdata;
    req.size     = size;
    req.wen      = wen;
    req.is_instr = 1'b0;
    return req;
  endfunction

endpackage : data_bus_pkg

// File: rtl/mem_arb_watchdog.sv
// Counts ACCESS cycles without a memory answer and flags expiry on the TIMEOUT-th one.
module mem_arb_watchdog
  import config_pkg::*;
#(
  parameter int unsigned TIMEOUT = CFG_MEMARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic m_ready,
  output logic expire
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // The current cycle is the TIMEOUT-th waiting cycle when the count already holds TIMEOUT-1.
  assign expire = enable && !m_ready && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = '0;
    if (enable && !m_ready && !expire) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : mem_arb_watchdog

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between a fetch requester and a data requester,
// data first, with a bounded data burst so fetches cannot starve.
module mem_port_arbiter
  import data_bus_pkg::*;
  import config_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = CFG_MEMARB_BURST,
  parameter int unsigned TIMEOUT        = CFG_MEMARB_TIMEOUT,
  parameter logic [31:0] FAULT_RDATA    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_ren,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_ren,
  input  logic        d_wen,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_size,
  output logic        m_ren,
  output logic        m_wen,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        fault
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  mem_arb_state_t state_q, state_d;
  mem_req_t       req_q, req_d;
  logic [3:0]     burst_q, burst_d;
  logic           m_ren_q, m_ren_d;
  logic           m_wen_q, m_wen_d;
  logic           i_ready_q, i_ready_d;
  logic           d_ready_q, d_ready_d;
  logic [31:0]    i_rdata_q, i_rdata_d;
  logic [31:0]    d_rdata_q, d_rdata_d;
  logic           fault_q, fault_d;

  logic           d_req;
  logic           grant_i;
  logic           grant_d;
  logic           expire;
  logic [31:0]    capture_data;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .enable  (state_q == ACCESS),
    .m_ready (m_ready),
    .expire  (expire)
  );

  assign d_req   = d_ren | d_wen;
  assign grant_i = i_ren && (!d_req || (burst_q == BURST_MAX));
  assign grant_d = d_req && !grant_i;

  // A real answer always wins; the watchdog only fires while m_ready is low.
  assign capture_data = m_ready ? m_rdata : FAULT_RDATA;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    burst_d   = burst_q;
    m_ren_d   = m_ren_q;
    m_wen_d   = m_wen_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    fault_d   = fault_q;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          req_d   = make_fetch_req(i_addr);
          burst_d = '0;
          m_ren_d = 1'b1;
          m_wen_d = 1'b0;
          state_d = ACCESS;
        end else if (grant_d) begin
          // Write wins when both data enables are raised together.
          req_d   = make_data_req(d_addr, d_wdata, d_size, d_wen);
          m_ren_d = !d_wen;
          m_wen_d = d_wen;
          state_d = ACCESS;
          if (!i_ren) begin
            burst_d = '0;
          end else if (burst_q != BURST_MAX) begin
            burst_d = burst_q + 4'd1;
          end
        end
      end

      ACCESS: begin
        if (m_ready || expire) begin
          m_ren_d = 1'b0;
          m_wen_d = 1'b0;
          state_d = DONE;
          if (expire) begin
            fault_d = 1'b1;
          end
          if (req_q.is_instr) begin
            i_ready_d = 1'b1;
            i_rdata_d = capture_data;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = capture_data;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        m_ren_d = 1'b0;
        m_wen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      burst_q   <= '0;
      m_ren_q   <= 1'b0;
      m_wen_q   <= 1'b0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      burst_q   <= burst_d;
      m_ren_q   <= m_ren_d;
      m_wen_q   <= m_wen_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      fault_q   <= fault_d;
    end
  end

  assign m_addr  = req_q.addr;
  assign m_wdata = req_q.wdata;
  assign m_size  = req_q.size;
  assign m_ren   = m_ren_q;
  assign m_wen   = m_wen_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign fault   = fault_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory responder plus one task per scenario.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic        i_ren, d_ren, d_wen, m_ready;
  logic [1:0]  d_size;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_ren, m_wen, fault;
  logic [1:0]  m_size;

  int checks = 0;
  int failures = 0;

  int memWait = 0;
  bit memHang = 1'b0;
  int accCycle = 0;

  typedef struct {
    bit          isInstr;
    logic [31:0] rdata;
  } exp_t;

  exp_t expQ[$];

  mem_port_arbiter #(
    .MAX_DATA_BURST (4),
    .TIMEOUT        (8),
    .FAULT_RDATA    (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_addr  (i_addr),
    .i_ren   (i_ren),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_size  (d_size),
    .d_ren   (d_ren),
    .d_wen   (d_wen),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_size  (m_size),
    .m_ren   (m_ren),
    .m_wen   (m_wen),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memModel(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0101;
  endfunction

  // Memory responder: answers after memWait stalled cycles unless memHang is set.
  always @(posedge clk) begin
    #2;
    if (m_ren || m_wen) begin
      if (!memHang && accCycle >= memWait) begin
        m_ready = 1'b1;
        m_rdata = memModel(m_addr);
      end else begin
        m_ready = 1'b0;
        m_rdata = 32'hDEAD_BEEF;
      end
      accCycle++;
    end else begin
      m_ready  = 1'b0;
      m_rdata  = 32'hDEAD_BEEF;
      accCycle = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input int maxCycles, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < maxCycles) begin
      tick();
      cycles++;
      if (i_ready === 1'b1 || d_ready === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({m_ren, m_wen, i_ready, d_ready, fault} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl actual=%b required=00000", {m_ren, m_wen, i_ready, d_ready, fault});
    end
    checks++;
    if ({m_addr, m_wdata, m_size} !== 66'b0) begin
      failures++;
      $display("[TB] FAIL reset_mbus actual=%h/%h/%b required=0", m_addr, m_wdata, m_size);
    end
    checks++;
    if ({i_rdata, d_rdata} !== 64'b0) begin
      failures++;
      $display("[TB] FAIL reset_rdata actual=%h/%h required=0", i_rdata, d_rdata);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({m_ren, m_wen} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL idle_no_request actual=%b required=00", {m_ren, m_wen});
    end
  endtask

  task automatic test_single_fetch();
    exp_t exp;
    i_addr = 32'h0000_0100;
    i_ren  = 1'b1;
    expQ.push_back('{1'b1, memModel(32'h0000_0100)});
    tick();
    checks++;
    if ({m_ren, m_wen, m_addr, m_size} !== {1'b1, 1'b0, 32'h0000_0100, 2'b10}) begin
      failures++;
      $display("[TB] FAIL fetch_access actual=ren%b wen%b addr%h size%b required=ren1 wen0 addr00000100 size10",
               m_ren, m_wen, m_addr, m_size);
    end
    tick();
    checks++;
    if ({i_ready, d_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL fetch_ready actual=i%b d%b required=i1 d0", i_ready, d_ready);
    end
    if (expQ.size() != 0) begin
      exp = expQ.pop_front();
      checks++;
      if (i_rdata !== exp.rdata) begin
        failures++;
        $display("[TB] FAIL fetch_rdata actual=%h required=%h", i_rdata, exp.rdata);
      end
    end
    i_ren = 1'b0;
    tick();
    checks++;
    if ({i_ready, m_ren} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL fetch_pulse actual=i_ready%b m_ren%b required=00", i_ready, m_ren);
    end
  endtask

  task automatic test_data_write_waits();
    exp_t exp;
    memWait = 2;
    d_addr  = 32'h0000_2000;
    d_wdata = 32'h1234_5678;
    d_size  = 2'b01;
    d_wen   = 1'b1;
    expQ.push_back('{1'b0, memModel(32'h0000_2000)});
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if ({m_wen, m_ren, m_addr, m_wdata, m_size} !== {1'b1, 1'b0, 32'h0000_2000, 32'h1234_5678, 2'b01}) begin
        failures++;
        $display("[TB] FAIL write_access_cyc%0d actual=wen%b ren%b %h %h %b required=wen1 ren0 00002000 12345678 01",
                 c, m_wen, m_ren, m_addr, m_wdata, m_size);
      end
    end
    tick();
    checks++;
    if ({d_ready, i_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL write_ready_cyc4 actual=d%b i%b required=d1 i0", d_ready, i_ready);
    end
    if (expQ.size() != 0) begin
      exp = expQ.pop_front();
      checks++;
      if (d_rdata !== exp.rdata) begin
        failures++;
        $display("[TB] FAIL write_rdata actual=%h required=%h", d_rdata, exp.rdata);
      end
    end
    d_wen   = 1'b0;
    memWait = 0;
    tick();
    checks++;
    if (i_rdata !== memModel(32'h0000_0100)) begin
      failures++;
      $display("[TB] FAIL other_side_rdata actual=%h required=%h", i_rdata, memModel(32'h0000_0100));
    end
  endtask

  task automatic test_contention();
    bit   expOrder[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t exp;
    int   cyc;
    bit   seen;
    i_addr = 32'h0000_0400;
    d_addr = 32'h0000_0800;
    d_size = 2'b10;
    i_ren  = 1'b1;
    d_ren  = 1'b1;
    for (int g = 0; g < 10; g++) begin
      expQ.push_back('{expOrder[g], memModel(expOrder[g] ? 32'h0000_0400 : 32'h0000_0800)});
      waitReady(12, cyc, seen);
      checks++;
      if (!seen) begin
        failures++;
        $display("[TB] FAIL contention_timeout grant=%0d actual=no_ready required=ready", g);
        expQ.delete();
        break;
      end
      exp = expQ.pop_front();
      if ({i_ready, d_ready} !== {exp.isInstr, !exp.isInstr}) begin
        failures++;
        $display("[TB] FAIL grant_order grant=%0d actual=i%b d%b required=i%b d%b",
                 g, i_ready, d_ready, exp.isInstr, !exp.isInstr);
      end
      checks++;
      if ((exp.isInstr ? i_rdata : d_rdata) !== exp.rdata) begin
        failures++;
        $display("[TB] FAIL contention_rdata grant=%0d actual=%h required=%h",
                 g, (exp.isInstr ? i_rdata : d_rdata), exp.rdata);
      end
      checks++;
      if (cyc != ((g == 0) ? 2 : 3)) begin
        failures++;
        $display("[TB] FAIL contention_spacing grant=%0d actual=%0d required=%0d", g, cyc, (g == 0) ? 2 : 3);
      end
    end
    i_ren = 1'b0;
    d_ren = 1'b0;
    tick();
  endtask

  task automatic test_read_write_collision();
    exp_t exp;
    int   wenCyc = 0;
    int   renCyc = 0;
    bit   seen = 1'b0;
    d_addr  = 32'h0000_2400;
    d_wdata = 32'hCAFE_F00D;
    d_size  = 2'b10;
    d_ren   = 1'b1;
    d_wen   = 1'b1;
    expQ.push_back('{1'b0, memModel(32'h0000_2400)});
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (m_wen === 1'b1) wenCyc++;
      if (m_ren === 1'b1) renCyc++;
      if (d_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || wenCyc != 1 || renCyc != 0) begin
      failures++;
      $display("[TB] FAIL rw_collision actual=ready%b wen_cycles%0d ren_cycles%0d required=ready1 wen_cycles1 ren_cycles0",
               seen, wenCyc, renCyc);
    end
    if (seen) begin
      exp = expQ.pop_front();
      checks++;
      if (d_rdata !== exp.rdata) begin
        failures++;
        $display("[TB] FAIL rw_collision_rdata actual=%h required=%h", d_rdata, exp.rdata);
      end
    end else begin
      expQ.delete();
    end
    d_ren = 1'b0;
    d_wen = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    exp_t exp;
    int   accCyc = 0;
    int   cyc;
    bit   seen = 1'b0;
    logic lastFault = 1'bx;
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fault_before_timeout actual=%b required=0", fault);
    end
    memHang = 1'b1;
    d_addr  = 32'h0000_3000;
    d_size  = 2'b10;
    d_ren   = 1'b1;
    expQ.push_back('{1'b0, 32'h0000_0000});
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (m_ren === 1'b1) begin
        accCyc++;
        lastFault = fault;
      end
      if (d_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || accCyc != 8) begin
      failures++;
      $display("[TB] FAIL timeout_cycles actual=ready%b access%0d required=ready1 access8", seen, accCyc);
    end
    checks++;
    if (fault !== 1'b1 || lastFault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_fault actual=done%b last_access%b required=done1 last_access0", fault, lastFault);
    end
    if (seen) begin
      exp = expQ.pop_front();
      checks++;
      if (d_rdata !== exp.rdata) begin
        failures++;
        $display("[TB] FAIL timeout_rdata actual=%h required=%h", d_rdata, exp.rdata);
      end
    end else begin
      expQ.delete();
    end
    d_ren   = 1'b0;
    memHang = 1'b0;
    tick();
    i_addr = 32'h0000_0104;
    i_ren  = 1'b1;
    expQ.push_back('{1'b1, memModel(32'h0000_0104)});
    waitReady(10, cyc, seen);
    checks++;
    if (!seen || i_ready !== 1'b1 || cyc != 2) begin
      failures++;
      $display("[TB] FAIL post_fault_fetch actual=i_ready%b cycles%0d required=i_ready1 cycles2", i_ready, cyc);
    end
    if (seen) begin
      exp = expQ.pop_front();
      checks++;
      if (i_rdata !== exp.rdata || fault !== 1'b1) begin
        failures++;
        $display("[TB] FAIL post_fault_data actual=%h fault%b required=%h fault1", i_rdata, fault, exp.rdata);
      end
    end else begin
      expQ.delete();
    end
    i_ren = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    exp_t exp;
    int   cyc;
    bit   seen;
    memHang = 1'b1;
    i_addr  = 32'h0000_0500;
    i_ren   = 1'b1;
    tick();
    checks++;
    if (m_ren !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_access_setup actual=m_ren%b required=1", m_ren);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({m_ren, m_wen, i_ready, d_ready, fault} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL async_reset actual=%b required=00000", {m_ren, m_wen, i_ready, d_ready, fault});
    end
    i_ren   = 1'b0;
    memHang = 1'b0;
    tick();
    tick();
    checks++;
    if ({i_ready, d_ready, m_ren} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_held actual=%b required=000", {i_ready, d_ready, m_ren});
    end
    rst = 1'b1;
    tick();
    i_addr = 32'h0000_0600;
    i_ren  = 1'b1;
    expQ.push_back('{1'b1, memModel(32'h0000_0600)});
    waitReady(10, cyc, seen);
    checks++;
    if (!seen || i_ready !== 1'b1 || cyc != 2) begin
      failures++;
      $display("[TB] FAIL post_reset_fetch actual=i_ready%b cycles%0d required=i_ready1 cycles2", i_ready, cyc);
    end
    if (seen) begin
      exp = expQ.pop_front();
      checks++;
      if (i_rdata !== exp.rdata) begin
        failures++;
        $display("[TB] FAIL post_reset_rdata actual=%h required=%h", i_rdata, exp.rdata);
      end
    end else begin
      expQ.delete();
    end
    i_ren = 1'b0;
    tick();
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    rst     = 1'b1;
    i_addr  = '0;
    i_ren   = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_size  = '0;
    d_ren   = 1'b0;
    d_wen   = 1'b0;
    m_ready = 1'b0;
    m_rdata = 32'hDEAD_BEEF;
    #1;
    rst = 1'b0;
    test_reset();
    test_single_fetch();
    test_data_write_waits();
    test_contention();
    test_read_write_collision();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_arbiter
